// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and
// the request/acknowledge bytes exchanged with the host.
package program_loader_pkg;

    typedef enum logic [2:0] {
        SEND_99,
        RX_SIZE,
        RX_DATA,
        FLUSH,
        SEND_AA,
        DONE
    } loader_state_t;

    localparam logic [7:0] LOAD_REQ_BYTE = 8'h99;
    localparam logic [7:0] LOAD_ACK_BYTE = 8'hAA;
    localparam logic [1:0] LAST_LANE     = 2'd3;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a byte stream little-endian into 32-bit words; a word started on lane 0
// clears the upper lanes so a partially filled word is always zero-padded.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [1:0]  lane_count,
    output logic        word_ready
);

    logic [31:0] word_reg;
    logic [1:0]  lane_count_reg;
    logic        word_ready_reg;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            word_reg       <= 32'h0;
            lane_count_reg <= 2'd0;
            word_ready_reg <= 1'b0;
        end else begin
            word_ready_reg <= byte_valid && (lane_count_reg == LAST_LANE);
            if (byte_valid) begin
                case (lane_count_reg)
                    2'd0:    word_reg          <= {24'h0, byte_data};
                    2'd1:    word_reg[15:8]    <= byte_data;
                    2'd2:    word_reg[23:16]   <= byte_data;
                    default: word_reg[31:24]   <= byte_data;
                endcase
                lane_count_reg <= lane_count_reg + 2'd1;
            end
        end
    end

    assign word       = word_reg;
    assign lane_count = lane_count_reg;
    assign word_ready = word_ready_reg;

endmodule

// File: rtl/program_loader.sv
// UART boot loader: requests a program with 0x99, receives a 32-bit size and the
// program bytes, writes them as words into program memory, then acknowledges with 0xAA.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              program_memory_wren,
    output logic [ADDR_W-1:0] program_memory_addr,
    output logic [31:0]       program_memory_wdata,
    output logic [31:0]       program_data_size,
    output logic              program_data_size_fetch_finished,
    output logic              program_data_fetch_finished
);

    loader_state_t state_reg;
    logic          tx_valid_reg;
    logic [7:0]    tx_data_reg;
    logic [31:0]   byte_count_reg;
    logic [31:0]   word_index_reg;
    logic          size_done_reg;
    logic          fetch_done_reg;

    logic [31:0]   size_word, data_word, size_next;
    logic [1:0]    size_lane, data_lane;
    logic          size_ready, data_ready;
    logic          size_byte_valid, data_byte_valid, assembler_clear;
    logic          word_commit, addr_in_range;

    assign size_byte_valid = rx_valid && (state_reg == RX_SIZE);
    assign data_byte_valid = rx_valid && (state_reg == RX_DATA);
    assign assembler_clear = (state_reg == SEND_99);
    assign size_next       = {rx_data, size_word[23:0]};
    // A full word lands the cycle after its 4th byte; FLUSH commits the padded tail.
    assign word_commit     = data_ready || (state_reg == FLUSH);
    assign addr_in_range   = (word_index_reg >> ADDR_W) == 32'd0;

    byte_assembler u_size_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (assembler_clear),
        .byte_valid (size_byte_valid),
        .byte_data  (rx_data),
        .word       (size_word),
        .lane_count (size_lane),
        .word_ready (size_ready)
    );

    byte_assembler u_data_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (assembler_clear),
        .byte_valid (data_byte_valid),
        .byte_data  (rx_data),
        .word       (data_word),
        .lane_count (data_lane),
        .word_ready (data_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= SEND_99;
            tx_valid_reg   <= 1'b0;
            tx_data_reg    <= 8'h00;
            byte_count_reg <= 32'd0;
            word_index_reg <= 32'd0;
            size_done_reg  <= 1'b0;
            fetch_done_reg <= 1'b0;
        end else begin
            size_done_reg <= size_done_reg | size_ready;
            if (word_commit) begin
                word_index_reg <= word_index_reg + 32'd1;
            end
            case (state_reg)
                SEND_99, SEND_AA: begin
                    if (!tx_valid_reg) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= (state_reg == SEND_99) ? LOAD_REQ_BYTE : LOAD_ACK_BYTE;
                    end else if (tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        if (state_reg == SEND_99) begin
                            state_reg <= RX_SIZE;
                        end else begin
                            state_reg      <= DONE;
                            fetch_done_reg <= 1'b1;
                        end
                    end
                end
                RX_SIZE: begin
                    if (rx_valid && (size_lane == LAST_LANE)) begin
                        state_reg <= (size_next == 32'd0) ? SEND_AA : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_valid) begin
                        byte_count_reg <= byte_count_reg + 32'd1;
                        if (byte_count_reg == size_word - 32'd1) begin
                            state_reg <= (data_lane == LAST_LANE) ? SEND_AA : FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_reg <= SEND_AA;
                end
                default: begin
                    state_reg <= DONE;
                end
            endcase
        end
    end

    assign tx_valid                         = tx_valid_reg;
    assign tx_data                          = tx_data_reg;
    assign program_memory_wren              = word_commit && addr_in_range;
    assign program_memory_addr              = word_index_reg[ADDR_W-1:0];
    assign program_memory_wdata             = data_word;
    assign program_data_size                = size_word;
    assign program_data_size_fetch_finished = size_done_reg | size_ready;
    assign program_data_fetch_finished      = fetch_done_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of complete loads plus hand-written
// handshake-stall and mid-load reset sequences.
module tb_program_loader;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       size;
    logic              size_fin;
    logic              fetch_fin;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk                              (clk),
        .reset_n                          (reset_n),
        .rx_valid                         (rx_valid),
        .rx_data                          (rx_data),
        .tx_ready                         (tx_ready),
        .tx_valid                         (tx_valid),
        .tx_data                          (tx_data),
        .program_memory_wren              (wren),
        .program_memory_addr              (addr),
        .program_memory_wdata             (wdata),
        .program_data_size                (size),
        .program_data_size_fetch_finished (size_fin),
        .program_data_fetch_finished      (fetch_fin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       size;
        logic [19:0][7:0]  data;
        logic [2:0]        exp_n;
        logic [4:0][31:0]  exp_words;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    logic [7:0]        tx_q [$];
    logic [31:0]       wr_data_q [$];
    logic [ADDR_W-1:0] wr_addr_q [$];

    // Capture every completed transfer and memory write at the clock edge.
    always @(posedge clk) begin
        if (wren) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
        end
        if (tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) tick();
        check32("rst tx_valid", tx_valid, 0);
        check32("rst tx_data", tx_data, 0);
        check32("rst wren", wren, 0);
        check32("rst addr", addr, 0);
        check32("rst wdata", wdata, 0);
        check32("rst size", size, 0);
        check32("rst size_fin", size_fin, 0);
        check32("rst fetch_fin", fetch_fin, 0);
        tx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 200 && tx_q.size() < n; i++) tick();
        check32("tx transfer count", tx_q.size(), n);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Assumes 0x99 has already been accepted; sends size + data and checks the result.
    task automatic load_and_check(input vec_t v, input string tag);
        logic [7:0] exp_tx [2];
        exp_tx[0] = 8'h99;
        exp_tx[1] = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            send_byte(v.size[8*k +: 8]);
            if (k == 3) begin
                check32("size after 4th byte", size, v.size);
                check32("size_fin after 4th byte", size_fin, 1);
            end
            tick();
        end
        for (int k = 0; k < int'(v.size) && k < 20; k++) begin
            send_byte(v.data[k]);
            tick();
        end
        for (int i = 0; i < 100 && !fetch_fin; i++) tick();
        check32("fetch_finished", fetch_fin, 1);
        send_byte(8'h5A);
        repeat (3) tick();
        check32("tx byte count", tx_q.size(), 2);
        for (int i = 0; i < tx_q.size() && i < 2; i++) check32("tx byte", tx_q[i], exp_tx[i]);
        check32("write count", wr_data_q.size(), v.exp_n);
        for (int i = 0; i < wr_data_q.size() && i < int'(v.exp_n); i++) begin
            check32("write addr", wr_addr_q[i], i);
            check32("write data", wr_data_q[i], v.exp_words[i]);
        end
        check32("size held", size, v.size);
        check32("size_fin held", size_fin, 1);
        check32("fetch_fin held", fetch_fin, 1);
        $display("%s: size=%0d writes=%0d tx_bytes=%0d", tag, v.size, wr_data_q.size(), tx_q.size());
    endtask

    initial begin
        vec_t v;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;

        vecs[0] = '{size: 32'd8, data: 160'h00100093_00000013, exp_n: 3'd2,
                    exp_words: 160'h00100093_00000013};
        vecs[1] = '{size: 32'd6, data: 160'h0605_04030201, exp_n: 3'd2,
                    exp_words: 160'h00000605_04030201};
        vecs[2] = '{size: 32'd0, data: 160'h0, exp_n: 3'd0, exp_words: 160'h0};
        vecs[3] = '{size: 32'd1, data: 160'hAB, exp_n: 3'd1, exp_words: 160'h000000AB};
        vecs[4] = '{size: 32'd20, data: 160'h0, exp_n: 3'd4,
                    exp_words: 160'h1F1E1D1C_1B1A1918_17161514_13121110};
        for (int k = 0; k < 20; k++) vecs[4].data[k] = 8'h10 + 8'(k);
        vecs[5] = '{size: 32'd3, data: 160'h332211, exp_n: 3'd1, exp_words: 160'h00332211};

        for (int n = 0; n < 6; n++) begin
            tx_ready = 1'b1;
            do_reset();
            wait_tx(1);
            load_and_check(vecs[n], $sformatf("load %0d", n));
        end

        // Transmitter stalled: 0x99 must hold, and a stray rx byte must be ignored.
        tx_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            check32("stall tx_valid", tx_valid, 1);
            check32("stall tx_data", tx_data, 8'h99);
            rx_valid = (i == 1);
            rx_data  = 8'h55;
            tick();
        end
        check32("stall tx_valid cycle6", tx_valid, 1);
        tx_ready = 1'b1;
        tick();
        check32("stall tx_valid after", tx_valid, 0);
        check32("stall tx count", tx_q.size(), 1);
        v = '{size: 32'd4, data: 160'hDEADBEEF, exp_n: 3'd1, exp_words: 160'hDEADBEEF};
        load_and_check(v, "stall load");

        // Reset in the middle of the data phase discards the partial word.
        do_reset();
        tick();
        check32("req tx_valid", tx_valid, 1);
        check32("req tx_data", tx_data, 8'h99);
        tick();
        check32("req tx_valid drop", tx_valid, 0);
        for (int k = 0; k < 4; k++) begin
            send_byte((k == 0) ? 8'h08 : 8'h00);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h11 * 8'(k + 1));
            tick();
        end
        check32("mid-load writes", wr_data_q.size(), 0);
        do_reset();
        tick();
        check32("restart tx_valid", tx_valid, 1);
        check32("restart tx_data", tx_data, 8'h99);
        wait_tx(1);
        v = '{size: 32'd4, data: 160'h77665544, exp_n: 3'd1, exp_words: 160'h77665544};
        load_and_check(v, "reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, program-memory word-address width.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-005 SHALL have port rx_data  input  8  received byte.
REQ-006 SHALL have port tx_ready  input  1  UART transmitter can accept a byte.
REQ-007 SHALL have port tx_valid  output  1  byte offered to transmitter.
REQ-008 SHALL have port tx_data  output  8  byte offered to transmitter.
REQ-009 SHALL have port program_memory_wren  output  1  one-cycle write strobe.
REQ-010 SHALL have port program_memory_addr  output  ADDR_W  word address.
REQ-011 SHALL have port program_memory_wdata  output  32  instruction word.
REQ-012 SHALL have port program_data_size  output  32  received program size in bytes.
REQ-013 SHALL have port program_data_size_fetch_finished  output  1  level: size field complete.
REQ-014 SHALL have port program_data_fetch_finished  output  1  level: all program bytes stored and 0xAA sent.

Function
REQ-015 SHALL implement states SEND_99, RX_SIZE, RX_DATA, FLUSH, SEND_AA, DONE.
REQ-016 SEND_99: tx_valid=1, tx_data=0x99; on tx_valid&&tx_ready go to RX_SIZE next cycle.
REQ-017 tx_valid/tx_data SHALL stay stable until accepted; tx_valid=0 outside SEND_99/SEND_AA.
REQ-018 RX_SIZE: four accepted bytes form program_data_size little-endian (first byte = bits 7:0).
REQ-019 Cycle after 4th size byte: program_data_size valid, size_fetch_finished=1; state RX_DATA, or SEND_AA if size==0.
REQ-020 RX_DATA: bytes assembled little-endian into 32-bit words; byte counter counts to program_data_size.
REQ-021 Cycle after each 4th data byte: program_memory_wren=1 for exactly one cycle with assembled word and current address; address then increments by 1.
REQ-022 Address SHALL start at 0; words with address >= 2**ADDR_W SHALL be dropped (wren=0) but bytes still counted.
REQ-023 If size not a multiple of 4, after last byte go to FLUSH: write partial word zero-padded in upper bytes, one wren cycle, then SEND_AA.
REQ-024 SEND_AA: tx_data=0xAA with same handshake as REQ-016/017; on acceptance go to DONE.
REQ-025 DONE: program_data_fetch_finished=1; held until reset; all further rx bytes ignored.
REQ-026 rx_valid outside RX_SIZE/RX_DATA SHALL be ignored with no state change.
REQ-027 Byte counter and size SHALL be 32-bit unsigned; no wrap for size up to 2**32-1.
REQ-028 Size finished flag SHALL stay 1 from REQ-019 until reset.

Reset
REQ-029 While reset_n=0 at clk edge: state SEND_99 (tx_valid visible next cycle after release), all counters, address, assembled word, size cleared.
REQ-030 Reset outputs: tx_valid 0, tx_data 0x00, wren 0, addr 0, wdata 0, size 0, both finished flags 0.
REQ-031 Reset mid-load SHALL discard partial word and restart handshake from SEND_99.

Structure
REQ-032 Shared package SHALL hold loader state enum and constants LOAD_REQ_BYTE=8'h99, LOAD_ACK_BYTE=8'hAA.
REQ-033 A sub-module byte_assembler (byte shift-in, 2-bit lane count, clear, word-ready pulse) SHALL be used for both size and data words.

Verification
REQ-034 Reset release, tx_ready=1 -> tx_valid=1/tx_data=0x99 one cycle, then tx_valid=0.
REQ-035 tx_ready held 0 for 5 cycles -> tx_data 0x99 stable 5 cycles, transfer on cycle 6.
REQ-036 Size bytes 08 00 00 00, data 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093, then 0xAA, fetch_finished=1.
REQ-037 Size 06, data 01 02 03 04 05 06 -> addr0=0x04030201, addr1=0x00000605 (FLUSH), then 0xAA.
REQ-038 Size 0 -> size_fetch_finished=1, no wren, 0xAA sent directly.
REQ-039 Reset after 3 data bytes -> outputs per REQ-030, new 0x99, prior partial word never written.
